// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } i2c_state_t;

    localparam logic       I2C_ACK             = 1'b0;
    localparam logic       I2C_NACK            = 1'b1;
    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h29;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line, followed by a registered edge detector.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;

    // The bus idles high, so the reset value of 1 avoids a false edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            level   <= sync_p1;
            rise    <= sync_p1 & ~level;
            fall    <= ~sync_p1 & level;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte write/read, open-drain SDA.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy
);

    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic       sda_oe;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] shreg_next;
    i2c_state_t state;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (i2c_scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (i2c_sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign shreg_next = {shreg[6:0], sda_lvl};

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            addr_hit <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            addr_hit <= 1'b0;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= shreg_next;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                // The address byte is exposed on rx_data so rw can be read alongside addr_hit.
                                if (shreg[6:0] == TARGET_ADDR) begin
                                    addr_hit <= 1'b1;
                                    busy     <= 1'b1;
                                    rx_data  <= shreg_next;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ADDR_ACK;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (shreg[0] == 1'b0) begin
                                sda_oe <= 1'b0;
                                state  <= WRITE;
                            end else begin
                                shreg  <= tx_data;
                                tx_req <= 1'b1;
                                sda_oe <= ~tx_data[7];
                                state  <= READ;
                            end
                        end
                    end

                    WRITE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= shreg_next;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= shreg_next;
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= WRITE_ACK;
                        end
                    end

                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WRITE;
                        end
                    end

                    READ: begin
                        // shreg[7] is the bit on the wire; each fall after a clocked bit presents the next one.
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= READ_ACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end

                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_NACK) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            shreg   <= tx_data;
                            tx_req  <= 1'b1;
                            sda_oe  <= ~tx_data[7];
                            bit_cnt <= 4'd0;
                            state   <= READ;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator on an open-drain bus with pull-up.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam time Q = 100ns;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [7:0] tx_data;
    logic       tx_req, rx_valid, addr_hit, busy;
    logic [7:0] rx_data;
    wire        sda_bus;

    logic [7:0]  tx_tab [0:7];
    int unsigned cnt_rxv = 0;
    int unsigned cnt_txreq = 0;
    int unsigned cnt_hit = 0;
    logic [7:0]  hit_byte = 8'h00;

    int n_cmp = 0;
    int n_fail = 0;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    assign tx_data = tx_tab[cnt_txreq[2:0]];

    always #5 clk = ~clk;

    i2c_target dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (scl),
        .i2c_sda  (sda_bus),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .addr_hit (addr_hit),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (rx_valid) cnt_rxv <= cnt_rxv + 1;
        if (tx_req)   cnt_txreq <= cnt_txreq + 1;
        if (addr_hit) begin
            cnt_hit  <= cnt_hit + 1;
            hit_byte <= rx_data;
        end
    end

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic bus_start();
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b1; #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b0; #Q;
    endtask

    task automatic clock_bit(input logic b, output logic sampled);
        sda_low = ~b; #Q;
        scl = 1'b1;   #(Q/2);
        sampled = sda_bus;
        #(Q/2);
        scl = 1'b0;   #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(ack_bit, dummy);
    endtask

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] rd;
        int unsigned base_rxv, base_txreq, base_hit;

        tx_tab[0] = 8'h3C; tx_tab[1] = 8'hC3; tx_tab[2] = 8'h5A; tx_tab[3] = 8'hFF;
        tx_tab[4] = 8'h00; tx_tab[5] = 8'h81; tx_tab[6] = 8'h7E; tx_tab[7] = 8'h24;

        // Reset values
        #23;
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", 8'(rx_valid), 8'h00);
        chk("rst_tx_req", 8'(tx_req), 8'h00);
        chk("rst_addr_hit", 8'(addr_hit), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_sda", 8'(sda_bus), 8'h01);
        #40 rst = 1'b1;
        #Q;

        // Write 0xA5 to 0x29
        base_rxv = cnt_rxv; base_hit = cnt_hit;
        bus_start();
        write_byte(8'h52, ack);
        chk("wr_addr_ack", 8'(ack), 8'h00);
        chk("wr_addr_hit_cnt", 8'(cnt_hit - base_hit), 8'h01);
        chk("wr_hit_byte", hit_byte, 8'h52);
        write_byte(8'hA5, ack);
        chk("wr_data_ack", 8'(ack), 8'h00);
        chk("wr_rx_data", rx_data, 8'hA5);
        chk("wr_rx_valid_cnt", 8'(cnt_rxv - base_rxv), 8'h01);
        chk("wr_busy", 8'(busy), 8'h01);
        bus_stop();
        chk("wr_sda_after_stop", 8'(sda_bus), 8'h01);
        chk("wr_busy_after_stop", 8'(busy), 8'h00);

        // Address 0x30 is ignored
        base_rxv = cnt_rxv; base_hit = cnt_hit;
        bus_start();
        write_byte(8'h60, ack);
        chk("miss_addr_nack", 8'(ack), 8'h01);
        chk("miss_busy", 8'(busy), 8'h00);
        write_byte(8'hFF, ack);
        chk("miss_byte1_nack", 8'(ack), 8'h01);
        write_byte(8'h00, ack);
        chk("miss_byte2_nack", 8'(ack), 8'h01);
        chk("miss_hit_cnt", 8'(cnt_hit - base_hit), 8'h00);
        chk("miss_rx_valid_cnt", 8'(cnt_rxv - base_rxv), 8'h00);
        chk("miss_rx_data", rx_data, 8'hA5);
        bus_stop();

        // Read two bytes from 0x29: ACK then NACK
        base_txreq = cnt_txreq; base_hit = cnt_hit;
        bus_start();
        write_byte(8'h53, ack);
        chk("rd_addr_ack", 8'(ack), 8'h00);
        chk("rd_hit_byte", hit_byte, 8'h53);
        read_byte(rd, I2C_ACK);
        chk("rd_byte0", rd, 8'h3C);
        read_byte(rd, I2C_NACK);
        chk("rd_byte1", rd, 8'hC3);
        chk("rd_tx_req_cnt", 8'(cnt_txreq - base_txreq), 8'h02);
        chk("rd_state_idle", 8'(dut.state), 8'(IDLE));
        chk("rd_sda_released", 8'(sda_bus), 8'h01);
        chk("rd_busy", 8'(busy), 8'h00);
        bus_stop();

        // Write 0x12, repeated START, read
        base_hit = cnt_hit;
        bus_start();
        write_byte(8'h52, ack);
        write_byte(8'h12, ack);
        chk("rs_wr_ack", 8'(ack), 8'h00);
        chk("rs_rx_data", rx_data, 8'h12);
        bus_start();
        write_byte(8'h53, ack);
        chk("rs_rd_addr_ack", 8'(ack), 8'h00);
        chk("rs_hit_cnt", 8'(cnt_hit - base_hit), 8'h02);
        read_byte(rd, I2C_NACK);
        chk("rs_rd_byte", rd, 8'h5A);
        bus_stop();

        // Reset while the ACK is driven low
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(1'((8'h52 >> i) & 8'h01), dummy);
        sda_low = 1'b0; #Q;
        scl = 1'b1; #(Q/2);
        chk("rr_ack_low", 8'(sda_bus), 8'h00);
        chk("rr_busy_before", 8'(busy), 8'h01);
        rst = 1'b0;
        #1;
        chk("rr_sda_released", 8'(sda_bus), 8'h01);
        chk("rr_busy", 8'(busy), 8'h00);
        chk("rr_rx_data", rx_data, 8'h00);
        chk("rr_state", 8'(dut.state), 8'(IDLE));
        #(Q/2);
        scl = 1'b0; #Q;
        rst = 1'b1; #Q;
        bus_stop();

        // STOP in the middle of bit 4 of a write byte
        bus_start();
        write_byte(8'h52, ack);
        chk("ab_addr_ack", 8'(ack), 8'h00);
        base_rxv = cnt_rxv;
        clock_bit(1'b0, dummy);
        clock_bit(1'b1, dummy);
        clock_bit(1'b1, dummy);
        sda_low = 1'b1; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b0; #Q;
        chk("ab_state_idle", 8'(dut.state), 8'(IDLE));
        chk("ab_busy", 8'(busy), 8'h00);
        chk("ab_rx_valid_cnt", 8'(cnt_rxv - base_rxv), 8'h00);
        chk("ab_rx_data_kept", rx_data, 8'h52);
        #Q;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
